// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - state encodings and constants for the data-memory responder
package data_mem_resp_pkg;

  localparam int          WAIT_W   = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response channel bundle between CPU load/store path and responder
interface data_mem_responder_if;

  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respRData;
  logic        respErr;

  modport master (
    output reqValid, reqWe, reqAddr, reqWData, respReady,
    input  reqReady, respValid, respRData, respErr
  );

  modport slave (
    input  reqValid, reqWe, reqAddr, reqWData, respReady,
    output reqReady, respValid, respRData, respErr
  );

endinterface

// File: rtl/data_mem_responder_ram.sv
// rtl/data_mem_responder_ram.sv - single-port synchronous word RAM, read-before-write
module dm_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          dIn,
  output logic [31:0]          dOut
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= dIn;
    end
    dOut <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder (IDLE/WAIT/RESP); ADDR_CHECK_EN enables address error checks
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rstN,
  data_mem_responder_if.slave  bus
);

  state_t                state;
  logic [WAIT_W-1:0]     cnt;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_BITS-1:0]  idx_q;
  logic [31:0]           wdata_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [31:0]           rdata_q;
  logic                  rerr_q;

  logic                  accept;
  logic                  access;
  logic                  addr_err;
  logic                  ram_we;
  logic [ADDR_BITS-1:0]  ram_addr;
  logic [31:0]           ram_dout;

`ifdef ADDR_CHECK_EN
  assign addr_err = (bus.reqAddr[1:0] != 2'b00) || (bus.reqAddr[31:ADDR_BITS+2] != '0);
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{bus.reqAddr[31:ADDR_BITS+2], bus.reqAddr[1:0]};
`endif

  assign accept = (state == ST_IDLE) && ready_q && bus.reqValid;
  assign access = (state == ST_WAIT) && (cnt == '0);
  assign ram_we = access && we_q && !err_q;

  // Present the live request address while idle so the RAM word is already
  // registered by the access edge, even with zero wait states.
  assign ram_addr = (state == ST_IDLE) ? bus.reqAddr[ADDR_BITS+1:2] : idx_q;

  dm_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .dIn  (wdata_q),
    .dOut (ram_dout)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= bus.reqWe;
            err_q   <= addr_err;
            idx_q   <= bus.reqAddr[ADDR_BITS+1:2];
            wdata_q <= bus.reqWData;
            cnt     <= WAIT_W'(WAIT_CYCLES);
            ready_q <= 1'b0;
            state   <= ST_WAIT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (access) begin
            valid_q <= 1'b1;
            rerr_q  <= err_q;
            rdata_q <= err_q ? ERR_DATA : (we_q ? 32'h0 : ram_dout);
            state   <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.respReady) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.reqReady  = ready_q;
  assign bus.respValid = valid_q;
  assign bus.respRData = rdata_q;
  assign bus.respErr   = rerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder against a word-array model
module tb_data_mem_responder;

  localparam int AB = 10;
  localparam int WC = 2;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WC)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] model [0:(1<<AB)-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a);
`ifdef ADDR_CHECK_EN
    return ((a % 4) != 0) || (a >= (32'd1 << (AB + 2)));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % (1 << AB));
  endfunction

  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, input bit poke);
    int          t;
    int          lat;
    bit          e;
    logic [31:0] exp_d;
    logic [31:0] held;
    t = 0;
    while (bus.reqReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_wait", 32'(bus.reqReady), 32'd1);
    bus.reqValid = 1'b1;
    bus.reqWe    = we;
    bus.reqAddr  = addr;
    bus.reqWData = wdata;
    @(negedge clk);
    bus.reqValid = 1'b0;
    if (poke) begin
      // A competing store that must be ignored until the response completes.
      bus.reqValid = 1'b1;
      bus.reqWe    = 1'b1;
      bus.reqAddr  = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      bus.reqWData = $urandom;
    end
    e     = model_err(addr);
    exp_d = e ? 32'hDEADBEEF : (we ? 32'h0 : model[word_of(addr)]);
    if (!e && we) model[word_of(addr)] = wdata;
    lat = 1;
    while (bus.respValid !== 1'b1 && lat < 50) begin
      check("ready_low_in_wait", 32'(bus.reqReady), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(WC + 2));
    check("resp_data", bus.respRData, exp_d);
    check("resp_err", 32'(bus.respErr), 32'(e));
    held = bus.respRData;
    repeat (hold) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.respValid), 32'd1);
      check("bp_data", bus.respRData, held);
      check("bp_ready", 32'(bus.reqReady), 32'd0);
    end
    bus.respReady = 1'b1;
    bus.reqValid  = 1'b0;
    @(negedge clk);
    bus.respReady = 1'b0;
    check("valid_drop", 32'(bus.respValid), 32'd0);
    check("ready_back", 32'(bus.reqReady), 32'd1);
  endtask

  initial begin
    bus.reqValid  = 1'b0;
    bus.reqWe     = 1'b0;
    bus.reqAddr   = '0;
    bus.reqWData  = '0;
    bus.respReady = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.reqReady), 32'd0);
    check("rst_resp_valid", 32'(bus.respValid), 32'd0);
    check("rst_resp_data", bus.respRData, 32'd0);
    check("rst_resp_err", 32'(bus.respErr), 32'd0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 32'(bus.reqReady), 32'd1);

    for (int i = 0; i < (1 << AB); i++) begin
      txn(1'b1, 32'(i * 4), 32'h0, 0, 1'b0);
    end

    txn(1'b1, 32'h10, 32'hCAFEF00D, 0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 5, 1'b1);
    txn(1'b1, 32'h8, 32'hA5A5A5A5, 0, 1'b0);
    txn(1'b0, 32'h100A, 32'h0, 0, 1'b0);
    txn(1'b1, 32'h6, 32'h0BADF00D, 0, 1'b0);
    txn(1'b0, 32'h4, 32'h0, 0, 1'b0);

    // Reset in the middle of a store's wait states must drop the write.
    while (bus.reqReady !== 1'b1) @(negedge clk);
    bus.reqValid = 1'b1;
    bus.reqWe    = 1'b1;
    bus.reqAddr  = 32'h40;
    bus.reqWData = 32'h12345678;
    @(negedge clk);
    bus.reqValid = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    check("midwait_rst_valid", 32'(bus.respValid), 32'd0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    check("midwait_rst_ready", 32'(bus.reqReady), 32'd1);
    txn(1'b0, 32'h40, 32'h0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
